kd_prog_mem: RTL and testbench

//   Program/data memory that sits directly downstream of the CPU's external bus
//   (F_adr, F_data, M_RW). It serves CPU reads combinationally and performs CPU

---
 rtl/kd_prog_mem.sv | 125 ++++++++++++
 tb/tb_kd_prog_mem.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kd_prog_mem.sv
// Program/data memory on the CPU external bus, with a byte-stream loader that
// holds the CPU in reset while it fills memory from a length-prefixed stream.
module kd_prog_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       F_adr,
  inout  wire  [DATA_W-1:0] F_data,
  input  logic              M_RW,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              cpu_hold
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          hi_q, hi_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                accept;
  logic                ld_wr;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                in_range;
  logic [ADDR_W-1:0]   idx;
  logic                cpu_wr;
  logic [DATA_W-1:0]   rd_data;

  assign ld_ready = (state_q == S_LEN) || (state_q == S_HI) || (state_q == S_LO);
  assign ld_done  = (state_q == S_DONE);
  assign cpu_hold = cpu_hold_q;
  assign accept   = ld_valid && ld_ready;

  // A word count of 0 stands for a full memory: counting down from 0 wraps
  // through DEPTH-1, so the last word is always the one written at cnt == 1.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement leaves it unassigned and infers a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    ld_wr   = 1'b0;
    if (ld_start) begin
      state_d = S_LEN;
      ptr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_LEN: if (accept) begin
          cnt_d   = ADDR_W'(ld_data);
          ptr_d   = '0;
          state_d = S_HI;
        end
        S_HI: if (accept) begin
          hi_d    = ld_data;
          state_d = S_LO;
        end
        S_LO: if (accept) begin
          ld_wr   = 1'b1;
          ptr_d   = ptr_q + ADDR_W'(1);
          cnt_d   = cnt_q - ADDR_W'(1);
          state_d = (cnt_q == ADDR_W'(1)) ? S_DONE : S_HI;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    cpu_hold_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      cpu_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign in_range = (F_adr >> ADDR_W) == 16'd0;
  assign idx      = F_adr[ADDR_W-1:0];
  assign cpu_wr   = !cpu_hold_q && !M_RW && in_range;

  // NOTE: the array has no reset so it maps onto plain RAM; contents survive
  // reset. Loader and CPU writes are mutually exclusive because the loader
  // only writes while cpu_hold is set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ld_wr) begin
        mem[ptr_q] <= DATA_W'({hi_q, ld_data});
      end else if (cpu_wr) begin
        mem[idx] <= F_data;
      end
    end
  end

  assign rd_data = in_range ? mem[idx] : '0;
  assign F_data  = (M_RW && !cpu_hold_q) ? rd_data : 'z;

endmodule

// File: tb/tb_kd_prog_mem.sv
// Randomised scoreboard bench for kd_prog_mem: a word-level memory model
// predicts reads and load completions; a monitor compares them as they appear.
module tb_kd_prog_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] F_adr;
  wire  [15:0] F_data;
  logic        M_RW;
  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic        cpu_hold;

  logic        drv_en;
  logic [15:0] drv_val;
  logic        rd_req;

  assign F_data = drv_en ? drv_val : 16'hzzzz;

  kd_prog_mem dut (
    .clk      (clk),
    .reset    (reset),
    .F_adr    (F_adr),
    .F_data   (F_data),
    .M_RW     (M_RW),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [15:0] data;
    logic [15:0] addr;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ref_mem [256];
  logic [7:0]  stream[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    return (addr[15:8] == 8'd0) ? ref_mem[addr[7:0]] : 16'h0000;
  endfunction

  // Monitor: pops one expectation per observed load completion or CPU read.
  always @(negedge clk) begin
    bit ok;
    if (ld_done) begin
      ok = (sb.size() > 0) && sb[0].is_done;
      check("ld_done_expected", 32'(ok), 32'd1);
      if (ok) void'(sb.pop_front());
    end
    if (rd_req) begin
      ok = (sb.size() > 0) && !sb[0].is_done;
      check("read_expected", 32'(ok), 32'd1);
      if (ok) begin
        check($sformatf("read_%04h", sb[0].addr), 32'(F_data), 32'(sb[0].data));
        void'(sb.pop_front());
      end
    end
  end

  task automatic cpu_read(input logic [15:0] addr);
    exp_t e;
    e.is_done = 1'b0;
    e.addr    = addr;
    e.data    = model_read(addr);
    sb.push_back(e);
    M_RW   = 1'b1;
    drv_en = 1'b0;
    F_adr  = addr;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] val, input bit held);
    M_RW    = 1'b0;
    drv_en  = 1'b1;
    drv_val = val;
    F_adr   = addr;
    #1;
    check("write_bus_undriven_by_dut", 32'(F_data), 32'(val));
    tick();
    if (!held && addr[15:8] == 8'd0) ref_mem[addr[7:0]] = val;
    drv_en = 1'b0;
    M_RW   = 1'b1;
    F_adr  = 16'h0000;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    ld_valid = 1'b0;
    repeat (gap) tick();
    ld_valid = 1'b1;
    ld_data  = b;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      acc = ld_ready;
      tick();
    end
    ld_valid = 1'b0;
    check("byte_accepted", 32'(acc), 32'd1);
  endtask

  task automatic pulse_start();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("ready_in_len", 32'(ld_ready), 32'd1);
  endtask

  // Loads the length-prefixed bytes in `stream`; the model writes word k from
  // bytes 2k+1 (high) and 2k+2 (low) at address k mod 256.
  task automatic load_stream(input int gap_min, input int gap_max, input bit hold_write);
    exp_t e;
    int   n;
    pulse_start();
    if (hold_write) cpu_write(16'h0020, 16'hDEAD, 1'b1);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == stream.size() - 1) begin
        e.is_done = 1'b1;
        e.data    = '0;
        e.addr    = '0;
        sb.push_back(e);
      end
      send_byte(stream[i], int'($urandom_range(gap_max, gap_min)));
    end
    n = (stream[0] == 8'd0) ? 256 : int'(stream[0]);
    for (int k = 0; k < n; k++) ref_mem[k % 256] = {stream[1 + 2 * k], stream[2 + 2 * k]};
    check("hold_in_done", 32'(cpu_hold), 32'd1);
    check("ready_low_in_done", 32'(ld_ready), 32'd0);
    tick();
    check("hold_released", 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    int a;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
    reset = 1'b1; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    M_RW = 1'b0; F_adr = 16'h0000; drv_en = 1'b1; drv_val = 16'h5A5A; rd_req = 1'b0;

    // Reset state; the DUT must leave the bus alone while M_RW=0.
    tick(); tick();
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_ld_done", 32'(ld_done), 32'd0);
    check("rst_bus_released", 32'(F_data), 32'h5A5A);
    reset = 1'b0; drv_en = 1'b0; M_RW = 1'b1;
    tick();

    // Basic three-word load.
    stream = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    load_stream(0, 0, 1'b0);
    cpu_read(16'h0000); cpu_read(16'h0001); cpu_read(16'h0002);

    // CPU write/read, out-of-range read and ignored out-of-range write.
    cpu_write(16'h0010, 16'h00A5, 1'b0);
    cpu_read(16'h0010);
    cpu_read(16'h0110);
    cpu_write(16'h0110, 16'hFFFF, 1'b0);
    cpu_read(16'h0010);

    // One-word load with 3-cycle gaps; CPU write during hold is ignored.
    cpu_write(16'h0020, 16'h1111, 1'b0);
    check("ready_low_idle", 32'(ld_ready), 32'd0);
    stream = '{8'h01, 8'hAB, 8'hCD};
    load_stream(3, 3, 1'b1);
    cpu_read(16'h0000); cpu_read(16'h0020); cpu_read(16'h0001);

    // Full 256-word load, length byte 0.
    stream = '{8'h00};
    for (int i = 0; i < 512; i++) stream.push_back(8'($urandom));
    load_stream(0, 1, 1'b0);
    cpu_read(16'h0000); cpu_read(16'h00FF);
    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(255, 0));
      cpu_read(16'(a));
    end

    // Restart after 1.5 words; the byte accepted alongside ld_start is dropped.
    stream.delete();
    pulse_start();
    send_byte(8'h03, 0); send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0);
    ref_mem[0] = 16'h1122;
    ld_start = 1'b1; ld_valid = 1'b1; ld_data = 8'h44;
    tick();
    ld_start = 1'b0; ld_valid = 1'b0;
    check("restart_hold", 32'(cpu_hold), 32'd1);
    check("restart_ready", 32'(ld_ready), 32'd1);
    stream = '{8'h01, 8'h55, 8'h66};
    for (int i = 0; i < 3; i++) begin
      if (i == 2) sb.push_back('{is_done: 1'b1, data: 16'h0, addr: 16'h0});
      send_byte(stream[i], int'($urandom_range(1, 0)));
    end
    ref_mem[0] = 16'h5566;
    tick(); tick();
    check("restart_released", 32'(cpu_hold), 32'd0);
    cpu_read(16'h0000); cpu_read(16'h0001);

    // Reset mid-load keeps the words already written.
    pulse_start();
    send_byte(8'h04, 0); send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    send_byte(8'hCC, 0); send_byte(8'hDD, 0); send_byte(8'hEE, 0);
    ref_mem[0] = 16'hAABB;
    ref_mem[1] = 16'hCCDD;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midload_reset_hold", 32'(cpu_hold), 32'd0);
    check("midload_reset_ready", 32'(ld_ready), 32'd0);
    cpu_read(16'h0000); cpu_read(16'h0001); cpu_read(16'h0002);

    tick(); tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
